dcache_2way_top: RTL

Parametrised two-way set-associative data cache for the single-issue CPU, sitting between the core data port and the 256-bit data memory. It is write-back and write-allocate, uses one LRU bit per set, and keeps tag, valid, dirty and data storage in internal registers. It also has free-running hit/miss event counters for performance measurement. It replaces the direct-mapped data cache on the same CPU and memory handshakes.

---
 rtl/dcache_2way_top.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/dcache_2way_top.sv
// Two-way set-associative, write-back / write-allocate data cache with one LRU bit per set
// and free-running hit/miss event counters.
module dcache_2way_top #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256,
  parameter int SETS   = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] p1_addr_i,
  input  logic [31:0]       p1_data_i,
  input  logic              p1_MemRead_i,
  input  logic              p1_MemWrite_i,
  output logic [31:0]       p1_data_o,
  output logic              p1_stall_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [LINE_W-1:0] mem_data_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i,
  output logic [31:0]       hit_cnt_o,
  output logic [31:0]       miss_cnt_o
);
  localparam int OFF_W  = $clog2(LINE_W / 8);
  localparam int WSEL_W = OFF_W - 2;
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;

  typedef enum logic [2:0] {S_IDLE, S_MISS, S_WRITEBACK, S_READMISS, S_FILL} state_t;

  state_t state_q, state_d;
  logic victim_q, victim_d;
  logic mem_enable_q, mem_enable_d;
  logic mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [LINE_W-1:0] mem_data_q, mem_data_d;
  logic [31:0] hit_cnt_q, miss_cnt_q;

  logic [TAG_W-1:0]  tag_q  [2][SETS];
  logic [LINE_W-1:0] data_q [2][SETS];
  logic [SETS-1:0]   valid_q [2];
  logic [SETS-1:0]   dirty_q [2];
  logic [SETS-1:0]   lru_q;

  logic [TAG_W-1:0]  req_tag;
  logic [IDX_W-1:0]  req_idx;
  logic [WSEL_W-1:0] req_wsel;
  logic              req;
  logic              unused_addr_lsb;

  assign req_tag         = p1_addr_i[ADDR_W-1 -: TAG_W];
  assign req_idx         = p1_addr_i[OFF_W +: IDX_W];
  assign req_wsel        = p1_addr_i[2 +: WSEL_W];
  assign unused_addr_lsb = ^p1_addr_i[1:0];
  assign req             = p1_MemRead_i | p1_MemWrite_i;

  logic [1:0]        way_hit;
  logic [LINE_W-1:0] way_line [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_way
    assign way_hit[gi]  = valid_q[gi][req_idx] && (tag_q[gi][req_idx] == req_tag);
    assign way_line[gi] = data_q[gi][req_idx];
  end

  logic              hit_way;
  logic              idle_hit;
  logic [LINE_W-1:0] hit_line;
  logic              alloc_way;
  logic              fill;

  assign hit_way  = way_hit[1];
  assign hit_line = way_line[hit_way];
  // A freshly filled line already matches in FILL; completion is only allowed from IDLE.
  assign idle_hit = (state_q == S_IDLE) && req && (|way_hit);

  assign p1_stall_o = req && !idle_hit;
  assign p1_data_o  = idle_hit ? hit_line[{req_wsel, 5'd0} +: 32] : 32'd0;

  assign alloc_way = !valid_q[0][req_idx] ? 1'b0 :
                     !valid_q[1][req_idx] ? 1'b1 : lru_q[req_idx];

  always_comb begin
    state_d      = state_q;
    victim_d     = victim_q;
    mem_enable_d = mem_enable_q;
    mem_write_d  = mem_write_q;
    mem_addr_d   = mem_addr_q;
    mem_data_d   = mem_data_q;
    fill         = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req && !(|way_hit)) state_d = S_MISS;
      end
      S_MISS: begin
        victim_d     = alloc_way;
        mem_enable_d = 1'b1;
        if (valid_q[alloc_way][req_idx] && dirty_q[alloc_way][req_idx]) begin
          state_d     = S_WRITEBACK;
          mem_write_d = 1'b1;
          mem_addr_d  = {tag_q[alloc_way][req_idx], req_idx, {OFF_W{1'b0}}};
          mem_data_d  = way_line[alloc_way];
        end else begin
          state_d     = S_READMISS;
          mem_write_d = 1'b0;
          mem_addr_d  = {req_tag, req_idx, {OFF_W{1'b0}}};
        end
      end
      S_WRITEBACK: begin
        if (mem_ack_i) begin
          state_d     = S_READMISS;
          mem_write_d = 1'b0;
          mem_addr_d  = {req_tag, req_idx, {OFF_W{1'b0}}};
        end
      end
      S_READMISS: begin
        if (mem_ack_i) begin
          state_d      = S_FILL;
          mem_enable_d = 1'b0;
          fill         = 1'b1;
        end
      end
      S_FILL:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= S_IDLE;
      victim_q     <= 1'b0;
      mem_enable_q <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
      lru_q        <= '0;
      for (int w = 0; w < 2; w++) begin
        valid_q[w] <= '0;
        dirty_q[w] <= '0;
      end
    end else begin
      state_q      <= state_d;
      victim_q     <= victim_d;
      mem_enable_q <= mem_enable_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
      if (idle_hit) begin
        hit_cnt_q      <= hit_cnt_q + 32'd1;
        lru_q[req_idx] <= ~hit_way;
        if (p1_MemWrite_i) dirty_q[hit_way][req_idx] <= 1'b1;
      end else if ((state_q == S_IDLE) && req) begin
        miss_cnt_q <= miss_cnt_q + 32'd1;
      end
      if (fill) begin
        valid_q[victim_q][req_idx] <= 1'b1;
        dirty_q[victim_q][req_idx] <= 1'b0;
        lru_q[req_idx]             <= ~victim_q;
      end
    end
  end

  // Tags and line data need no reset: the valid bits gate every use.
  always_ff @(posedge clk_i) begin
    if (fill) begin
      data_q[victim_q][req_idx] <= mem_data_i;
      tag_q[victim_q][req_idx]  <= req_tag;
    end else if (idle_hit && p1_MemWrite_i) begin
      data_q[hit_way][req_idx][{req_wsel, 5'd0} +: 32] <= p1_data_i;
    end
  end

  assign mem_enable_o = mem_enable_q;
  assign mem_write_o  = mem_write_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_data_o   = mem_data_q;
  assign hit_cnt_o    = hit_cnt_q;
  assign miss_cnt_o   = miss_cnt_q;

endmodule
